// File: rtl/fb_pkg.sv
// Shared definitions for the ping-pong frame buffer: FSM encoding, bank sizing and
// the LCD geometry that fixes the frame length.
package fb_pkg;

    localparam int unsigned LCD_WIDTH  = 120;
    localparam int unsigned LCD_HEIGHT = 64;
    localparam int unsigned LCD_BPP    = 2;

    localparam int unsigned DEFAULT_BANK_AW     = 14;
    localparam int unsigned DEFAULT_FRAME_BYTES = LCD_WIDTH * LCD_HEIGHT * LCD_BPP;
    localparam int unsigned DEFAULT_CNT_W       = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRecv  = 2'd1,
        StCheck = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/cs_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus an edge-detect stage that emits
// one-cycle rise/fall pulses. Flops reset high so an idle active-low strobe reads inactive.
module cs_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_async,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= pin_async;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/frame_swap_ctrl.sv
// Ping-pong frame-buffer controller: SPI frames land in the back bank and the banks swap
// at an LCD vsync only after a frame of exactly FRAME_BYTES has been received.
module frame_swap_ctrl
    import fb_pkg::*;
#(
    parameter int unsigned BANK_AW     = DEFAULT_BANK_AW,
    parameter int unsigned FRAME_BYTES = DEFAULT_FRAME_BYTES,
    parameter int unsigned CNT_W       = DEFAULT_CNT_W
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               cs_n_async,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               vsync_start,
    input  logic [BANK_AW-1:0] lcd_addr,
    output logic               wr_en,
    output logic [BANK_AW:0]   wr_addr,
    output logic [7:0]         wr_data,
    output logic [BANK_AW:0]   rd_addr,
    output logic               disp_bank,
    output logic               frame_ready,
    output logic [CNT_W-1:0]   frame_count,
    output logic               err_short,
    output logic               err_overflow
);

    localparam logic [BANK_AW:0] FRAME_LEN = (BANK_AW + 1)'(FRAME_BYTES);

    logic             cs_rise;
    logic             cs_fall;
    logic             swap;
    fsm_state_t       state;
    logic [BANK_AW:0] byte_cnt;
    logic             ovf_flag;

    cs_sync_edge u_cs_sync (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .pin_async (cs_n_async),
        .rise      (cs_rise),
        .fall      (cs_fall)
    );

    // frame_ready is registered, so a frame validated in CHECK cannot swap in that same cycle.
    assign swap    = vsync_start && frame_ready;
    assign rd_addr = {disp_bank, lcd_addr};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= StIdle;
            byte_cnt     <= '0;
            ovf_flag     <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            disp_bank    <= 1'b0;
            frame_ready  <= 1'b0;
            frame_count  <= '0;
            err_short    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            wr_en <= 1'b0;

            if (swap) begin
                disp_bank   <= ~disp_bank;
                frame_ready <= 1'b0;
                frame_count <= frame_count + CNT_W'(1);
            end

            unique case (state)
                StIdle: begin
                    if (cs_fall) begin
                        // Latest frame wins: a pending, unswapped frame is discarded.
                        byte_cnt    <= '0;
                        ovf_flag    <= 1'b0;
                        frame_ready <= 1'b0;
                        state       <= StRecv;
                    end
                end
                StRecv: begin
                    if (cs_fall) begin
                        byte_cnt <= '0;
                        ovf_flag <= 1'b0;
                    end else begin
                        if (rx_valid) begin
                            if (byte_cnt < FRAME_LEN) begin
                                // Back bank sampled now; a swap cannot occur while receiving.
                                wr_en    <= 1'b1;
                                wr_addr  <= {~disp_bank, byte_cnt[BANK_AW-1:0]};
                                wr_data  <= rx_data;
                                byte_cnt <= byte_cnt + 1'b1;
                            end else begin
                                ovf_flag <= 1'b1;
                            end
                        end
                        if (cs_rise) begin
                            state <= StCheck;
                        end
                    end
                end
                StCheck: begin
                    state <= StIdle;
                    if (ovf_flag) begin
                        err_overflow <= 1'b1;
                    end else if (byte_cnt != FRAME_LEN) begin
                        err_short <= 1'b1;
                    end else begin
                        frame_ready <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/frame_swap_ctrl.md
Name: frame_swap_ctrl

Overview:
Ping-pong frame-buffer controller placed between the SPI byte stream, the 32 KB image BSRAM and the LCD controller. It splits the BSRAM into two banks. Incoming SPI frames always land in the back bank. The banks swap only at an LCD frame boundary, and only after a frame with exactly the right length is complete. This keeps the display free of tearing and of partially written frames.

Parameters:
BANK_AW, 14, address width of one bank; bank size is 2^BANK_AW bytes (16384)
FRAME_BYTES, 15360, exact byte count of a valid frame; must be ≤ 2^BANK_AW
CNT_W, 8, width of frame_count

Ports:
sys_clk  in  1  system clock, 27 MHz
sys_rst_n  in  1  reset, asynchronous assert, active-low
cs_n_async  in  1  ESP SPI chip select, asynchronous; synchronized internally
rx_data  in  8  received byte from the SPI slave (sys_clk domain)
rx_valid  in  1  one-cycle strobe qualifying rx_data
vsync_start  in  1  one-cycle pulse from the LCD at the start of vertical blanking
lcd_addr  in  BANK_AW  pixel byte address requested by the LCD
wr_en  out  1  BSRAM write enable
wr_addr  out  BANK_AW+1  BSRAM write address; MSB is the back bank
wr_data  out  8  BSRAM write data
rd_addr  out  BANK_AW+1  {disp_bank, lcd_addr}; combinational
disp_bank  out  1  bank currently being displayed
frame_ready  out  1  a validated frame is waiting for a swap
frame_count  out  CNT_W  number of swaps performed; wraps
err_short  out  1  sticky; a frame ended with fewer than FRAME_BYTES bytes
err_overflow  out  1  sticky; a frame carried more than FRAME_BYTES bytes

Behaviour:
- Reset values: all outputs 0, disp_bank=0, FSM=IDLE, byte counter 0, sync flops at 1 (CS inactive).
- CS synchronization: two-flop synchronizer followed by an edge-detect register. cs_fall and cs_rise are one-cycle pulses, 3 cycles after the pin edge.
- Back bank is always ~disp_bank.
- FSM IDLE: on cs_fall, clear the byte counter and go to RECV. rx_valid is ignored in IDLE.
- FSM RECV:
  - On rx_valid, if count < FRAME_BYTES: next cycle wr_en=1, wr_addr={~disp_bank, count}, wr_data=rx_data; count increments. Write latency is exactly 1 cycle.
  - On rx_valid with count ≥ FRAME_BYTES: no write; set ovf_flag.
  - On cs_rise: go to CHECK.
- FSM CHECK (1 cycle), then IDLE:
  - ovf_flag set: err_overflow<=1; frame rejected.
  - Else count ≠ FRAME_BYTES: err_short<=1; frame rejected.
  - Else: frame_ready<=1.
- Swap: when vsync_start && frame_ready, then disp_bank<=~disp_bank, frame_ready<=0, frame_count<=frame_count+1 (wraps). Effective from the next cycle.
- cs_fall while frame_ready=1: frame_ready is cleared (latest frame wins) and the new frame overwrites the same back bank.
- vsync_start and cs_fall in the same cycle with frame_ready=1: the swap wins. The new frame targets the newly freed bank, which is ~(new disp_bank).
- CHECK and vsync_start in the same cycle: no swap. frame_ready is visible from the next cycle, so the swap happens at the following vsync.
- cs_rise in IDLE: ignored. cs_fall in RECV (glitch): restart, clearing count and ovf_flag.
- Sticky errors clear only on reset.
- Reset mid-frame: the partial frame is abandoned, and display returns to bank 0 on release.

Decomposition:
- Shared package fb_pkg holds:
  - FSM state encoding: IDLE, RECV, CHECK
  - default BANK_AW and FRAME_BYTES
  - LCD frame geometry constants (width, height, bytes per pixel) from which FRAME_BYTES is derived
- One sub-module, cs_sync_edge: two-flop synchronizer plus rise/fall pulse generator. Reused by any other pin-level strobes.

Test Plan:
- Good frame: after reset, send 15360 bytes 0x00..0xFF repeating, raise CS, pulse vsync_start → writes hit addresses 0x4000..0x7BFF in order; frame_ready=1 after CHECK; after vsync disp_bank=1, frame_count=1, rd_addr MSB=1.
- Short frame: send 100 bytes, raise CS → err_short=1, frame_ready=0; a later vsync does not change disp_bank.
- Overflow: send 15361 bytes → exactly 15360 wr_en pulses, last wr_addr=0x7BFF; err_overflow=1; no swap.
- Latest wins: frame A valid with no vsync, then frame B valid → frame_ready drops at B's cs_fall and rises after B's CHECK; B's bytes are written to the same bank; one vsync gives frame_count=1.
- Collision: frame_ready=1, vsync_start and cs_fall forced in the same cycle → disp_bank flips; the next frame's wr_addr MSB equals the old disp_bank.
- Reset mid-frame: assert sys_rst_n low after 5000 bytes → all outputs 0 asynchronously; after release, a full valid frame writes to bank 1 and swaps normally.
